// File: rtl/transfer_packer.sv
// transfer_packer
// Packs a stream of DATA_W-bit input beats into LANES-wide output transfers.
// A transfer closes when all lanes are filled, when a beat carries in_last,
// or when a flush request is pending. The output is a single registered
// word with a valid/ready handshake. Lanes that were never filled read 0.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : input beat valid
//   in_ready    : input beat accepted when in_valid && in_ready
//   in_data     : input beat payload (DATA_W)
//   in_last     : beat closes the current transfer
//   flush       : single-cycle request to emit a partial transfer
//   out_valid   : packed transfer valid
//   out_ready   : downstream accepts when out_valid && out_ready
//   out_data    : packed lanes, lane k at [k*DATA_W +: DATA_W]
//   out_count   : number of valid lanes (1..LANES)
//   out_last    : transfer was closed by in_last
//   xfer_cnt    : completed output handshakes (wraps at 16 bits)
module transfer_packer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  localparam int CNT_W = $clog2(LANES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]          out_count,
  output logic                      out_last,
  output logic [15:0]               xfer_cnt
);

  logic [LANES*DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
  logic                    flush_pend_q, flush_pend_d;
  logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]        out_count_q, out_count_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;
  logic [15:0]             xfer_cnt_q, xfer_cnt_d;

  logic                    in_ready_s;
  logic                    accept_s;
  logic                    out_hs_s;
  logic                    last_lane_s;
  logic                    flush_eff_s;
  logic                    beat_done_s;
  logic                    flush_emit_s;
  logic                    load_s;
  logic [LANES*DATA_W-1:0] merged_s;

  // The output slot can take a new word whenever it is empty or draining now.
  assign in_ready_s = !out_valid_q || out_ready;
  assign accept_s   = in_valid && in_ready_s;
  assign out_hs_s   = out_valid_q && out_ready;

  // Accumulator with the accepted beat dropped into its lane.
  always_comb begin
    merged_s = acc_q;
    for (int k = 0; k < LANES; k++) begin
      if (accept_s && (CNT_W'(k) == acc_cnt_q)) begin
        merged_s[k*DATA_W +: DATA_W] = in_data;
      end else begin
        merged_s[k*DATA_W +: DATA_W] = acc_q[k*DATA_W +: DATA_W];
      end
    end
  end

  // Transfer-close decision and next-state for all registers.
  always_comb begin
    last_lane_s  = (acc_cnt_q == CNT_W'(LANES - 1));
    // A flush arriving this cycle acts immediately, otherwise the latched one.
    flush_eff_s  = flush || flush_pend_q;
    beat_done_s  = accept_s && (last_lane_s || in_last || flush_eff_s);
    // Partial emit only with something to send; an empty accumulator keeps
    // the flush pending for the next accepted beat.
    flush_emit_s = !accept_s && in_ready_s && flush_eff_s && (acc_cnt_q != '0);
    load_s       = beat_done_s || flush_emit_s;

    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    flush_pend_d = flush_pend_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    xfer_cnt_d   = xfer_cnt_q;

    if (load_s) begin
      out_data_d   = merged_s;
      out_count_d  = beat_done_s ? (acc_cnt_q + CNT_W'(1)) : acc_cnt_q;
      out_last_d   = beat_done_s && in_last;
      out_valid_d  = 1'b1;
      acc_d        = '0;
      acc_cnt_d    = '0;
      flush_pend_d = 1'b0;
    end else begin
      if (out_hs_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      if (accept_s) begin
        acc_d     = merged_s;
        acc_cnt_d = acc_cnt_q + CNT_W'(1);
      end else begin
        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
      end
      if (flush) begin
        flush_pend_d = 1'b1;
      end else begin
        flush_pend_d = flush_pend_q;
      end
    end

    if (out_hs_s) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end else begin
      xfer_cnt_d = xfer_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      xfer_cnt_q   <= 16'd0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_transfer_packer.sv
module tb_transfer_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: DATA_W=8, LANES=4
  logic        in_valid_a, in_ready_a, in_last_a, flush_a;
  logic [7:0]  in_data_a;
  logic        out_valid_a, out_ready_a, out_last_a;
  logic [31:0] out_data_a;
  logic [2:0]  out_count_a;
  logic [15:0] xfer_cnt_a;

  // DUT B: DATA_W=8, LANES=1
  logic        in_valid_b, in_ready_b, in_last_b, flush_b;
  logic [7:0]  in_data_b;
  logic        out_valid_b, out_ready_b, out_last_b;
  logic [7:0]  out_data_b;
  logic [0:0]  out_count_b;
  logic [15:0] xfer_cnt_b;

  transfer_packer #(.DATA_W(8), .LANES(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .in_last(in_last_a), .flush(flush_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_count(out_count_a), .out_last(out_last_a), .xfer_cnt(xfer_cnt_a)
  );

  transfer_packer #(.DATA_W(8), .LANES(1)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .in_last(in_last_b), .flush(flush_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_count(out_count_b), .out_last(out_last_b), .xfer_cnt(xfer_cnt_b)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  c;
    logic        l;
  } exp_a_t;

  typedef struct packed {
    logic [7:0]  d;
    logic [0:0]  c;
    logic        l;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_a_t mk_a(input logic [31:0] d, input logic [2:0] c, input logic l);
    exp_a_t e;
    e.d = d; e.c = c; e.l = l;
    return e;
  endfunction

  // Scoreboard monitor for DUT A: every output handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready_a) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL mon_a_unexpected actual=%h expected=none", out_data_a);
      end else begin
        exp_a_t e;
        e = qa.pop_front();
        chk("mon_a_data",  64'(out_data_a),  64'(e.d));
        chk("mon_a_count", 64'(out_count_a), 64'(e.c));
        chk("mon_a_last",  64'(out_last_a),  64'(e.l));
      end
    end
  end

  // Scoreboard monitor for DUT B.
  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready_b) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL mon_b_unexpected actual=%h expected=none", out_data_b);
      end else begin
        exp_b_t e;
        e = qb.pop_front();
        chk("mon_b_data",  64'(out_data_b),  64'(e.d));
        chk("mon_b_count", 64'(out_count_b), 64'(e.c));
        chk("mon_b_last",  64'(out_last_b),  64'(e.l));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Offer one beat to DUT A and wait (bounded) for it to be accepted.
  task automatic beat_a(input logic [7:0] d, input logic l, input logic f);
    logic ok;
    ok = 1'b0;
    in_valid_a = 1'b1; in_data_a = d; in_last_a = l; flush_a = f;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready_a) ok = 1'b1;
      step();
    end
    in_valid_a = 1'b0; in_last_a = 1'b0; flush_a = 1'b0;
    chk("beat_a_accept_timeout", 64'(ok), 64'(1'b1));
  endtask

  initial begin
    rst = 1'b1;
    in_valid_a = 1'b0; in_data_a = 8'h00; in_last_a = 1'b0; flush_a = 1'b0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_data_b = 8'h00; in_last_b = 1'b0; flush_b = 1'b0; out_ready_b = 1'b1;
    step(); step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_a), 64'(1'b0));
    chk("rst_out_data",  64'(out_data_a),  64'(32'h0));
    chk("rst_out_count", 64'(out_count_a), 64'(3'd0));
    chk("rst_out_last",  64'(out_last_a),  64'(1'b0));
    chk("rst_xfer_cnt",  64'(xfer_cnt_a),  64'(16'd0));
    chk("rst_in_ready",  64'(in_ready_a),  64'(1'b1));
    step();

    // Full four-lane transfer
    qa.push_back(mk_a(32'h44332211, 3'd4, 1'b0));
    beat_a(8'h11, 1'b0, 1'b0);
    beat_a(8'h22, 1'b0, 1'b0);
    beat_a(8'h33, 1'b0, 1'b0);
    beat_a(8'h44, 1'b0, 1'b0);
    step();
    chk("full_xfer_cnt", 64'(xfer_cnt_a), 64'(16'd1));

    // Partial transfer closed by in_last
    qa.push_back(mk_a(32'h0000BBAA, 3'd2, 1'b1));
    beat_a(8'hAA, 1'b0, 1'b0);
    beat_a(8'hBB, 1'b1, 1'b0);
    step(); step();

    // Backpressure: word held, input stalls, then back-to-back replace
    out_ready_a = 1'b0;
    qa.push_back(mk_a(32'h04030201, 3'd4, 1'b0));
    beat_a(8'h01, 1'b0, 1'b0);
    beat_a(8'h02, 1'b0, 1'b0);
    beat_a(8'h03, 1'b0, 1'b0);
    beat_a(8'h04, 1'b0, 1'b0);
    qa.push_back(mk_a(32'h00000099, 3'd1, 1'b1));
    in_valid_a = 1'b1; in_data_a = 8'h99; in_last_a = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("hold_in_ready",  64'(in_ready_a),  64'(1'b0));
      chk("hold_out_valid", 64'(out_valid_a), 64'(1'b1));
      chk("hold_out_data",  64'(out_data_a),  64'(32'h04030201));
      step();
    end
    out_ready_a = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready_a), 64'(1'b1));
    step();
    in_valid_a = 1'b0; in_last_a = 1'b0;
    @(negedge clk);
    chk("b2b_out_valid", 64'(out_valid_a), 64'(1'b1));
    step();
    @(negedge clk);
    chk("drain_out_valid", 64'(out_valid_a), 64'(1'b0));
    step();

    // Flush of a three-lane partial
    qa.push_back(mk_a(32'h00030201, 3'd3, 1'b0));
    beat_a(8'h01, 1'b0, 1'b0);
    beat_a(8'h02, 1'b0, 1'b0);
    beat_a(8'h03, 1'b0, 1'b0);
    step();
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    step(); step();

    // Flush with empty accumulator stays pending for the next beat
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    step(); step(); step();
    @(negedge clk);
    chk("pend_no_output", 64'(out_valid_a), 64'(1'b0));
    step();
    qa.push_back(mk_a(32'h00000055, 3'd1, 1'b0));
    beat_a(8'h55, 1'b0, 1'b0);
    step(); step();

    // Reset mid-transfer discards the partial accumulator
    beat_a(8'hE1, 1'b0, 1'b0);
    beat_a(8'hE2, 1'b0, 1'b0);
    rst = 1'b1; in_valid_a = 1'b1; in_data_a = 8'h77; flush_a = 1'b1;
    step();
    rst = 1'b0; in_valid_a = 1'b0; flush_a = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready",  64'(in_ready_a),  64'(1'b1));
    chk("mid_rst_out_valid", 64'(out_valid_a), 64'(1'b0));
    chk("mid_rst_xfer_cnt",  64'(xfer_cnt_a),  64'(16'd0));
    step();
    qa.push_back(mk_a(32'h13121110, 3'd4, 1'b0));
    beat_a(8'h10, 1'b0, 1'b0);
    beat_a(8'h11, 1'b0, 1'b0);
    beat_a(8'h12, 1'b0, 1'b0);
    beat_a(8'h13, 1'b0, 1'b0);
    step();
    chk("post_rst_xfer_cnt", 64'(xfer_cnt_a), 64'(16'd1));

    // LANES=1: continuous stream, one transfer per cycle, counter wrap
    in_valid_b = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      exp_b_t e;
      in_data_b = i[7:0];
      e.d = i[7:0]; e.c = 1'b1; e.l = 1'b0;
      qb.push_back(e);
      @(negedge clk);
      if (in_ready_b !== 1'b1) begin
        chk("lane1_in_ready", 64'(in_ready_b), 64'(1'b1));
      end
      if (i > 0 && out_valid_b !== 1'b1) begin
        chk("lane1_no_bubble", 64'(out_valid_b), 64'(1'b1));
      end
      if (i == 1 || i == 65535) begin
        chk("lane1_valid", 64'(out_valid_b), 64'(1'b1));
      end
      step();
    end
    in_valid_b = 1'b0;
    @(negedge clk);
    chk("xfer_cnt_ffff", 64'(xfer_cnt_b), 64'(16'hFFFF));
    step();
    @(negedge clk);
    chk("xfer_cnt_wrap", 64'(xfer_cnt_b), 64'(16'h0000));
    chk("lane1_idle",    64'(out_valid_b), 64'(1'b0));
    step();

    // Drain check
    for (int n = 0; n < 20 && (qa.size() != 0 || qb.size() != 0); n++) step();
    chk("qa_drained", 64'(qa.size()), 64'(0));
    chk("qb_drained", 64'(qb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transfer_packer.md
TRANSFER_PACKER -- requirements
Module: transfer_packer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, bit width of one input beat (payload element).
REQ-002 The block SHALL have parameter LANES, default 4, number of beats packed per output transfer (LANES >= 1).
REQ-003 The block SHALL derive localparam CNT_W = $clog2(LANES+1), the width of lane counts.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with the ports below.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-009 in_data  input  DATA_W  input beat payload.
REQ-010 in_last  input  1  beat closes the current transfer (partial allowed).
REQ-011 flush  input  1  single-cycle request to emit a partial transfer.
REQ-012 out_valid  output  1  packed transfer valid.
REQ-013 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-014 out_data  output  LANES*DATA_W  packed lanes; lane k in bits [k*DATA_W +: DATA_W].
REQ-015 out_count  output  CNT_W  number of valid lanes, 1..LANES.
REQ-016 out_last  output  1  transfer closed by in_last.
REQ-017 xfer_cnt  output  16  count of completed output handshakes.

Function
REQ-018 State: accumulator (LANES lanes), acc_cnt (0..LANES-1), flush_pend, one output register (data/count/last/valid), xfer_cnt.
REQ-019 in_ready SHALL equal !out_valid || out_ready (combinational from out_ready; no dependency on in_valid).
REQ-020 Accepted beat SHALL be written to lane acc_cnt; acc_cnt increments.
REQ-021 Accepted beat SHALL complete a transfer when acc_cnt == LANES-1 or in_last == 1.
REQ-022 On completion, accumulator plus the completing beat SHALL load the output register in the same edge; out_valid=1 from the next cycle (latency 1 cycle from last beat).
REQ-023 On completion, acc_cnt SHALL return to 0 and accumulator lanes SHALL clear to 0.
REQ-024 Unused lanes (index >= out_count) SHALL read as 0.
REQ-025 out_last SHALL be 1 only if the completing beat had in_last=1; a full-lane transfer without in_last has out_last=0.
REQ-026 flush SHALL set flush_pend; flush_pend SHALL be cleared when any transfer loads the output register.
REQ-027 flush_pend with acc_cnt > 0, in_ready=1 and no accepted beat SHALL emit a partial transfer of acc_cnt lanes, out_last=0.
REQ-028 flush in the same cycle as an accepted beat SHALL include that beat; transfer emitted that edge with out_last = in_last.
REQ-029 flush_pend with acc_cnt == 0 and no beat SHALL remain pending and apply to the next accepted beat (emitted as 1-lane transfer).
REQ-030 While in_ready == 0, accumulator, acc_cnt and input-side state SHALL hold; flush is still latched.
REQ-031 Output register SHALL hold stable while out_valid && !out_ready.
REQ-032 Output handshake with simultaneous new completion SHALL replace the register (back-to-back, no bubble); out_valid stays 1.
REQ-033 Output handshake without new completion SHALL clear out_valid next cycle.
REQ-034 xfer_cnt SHALL increment by 1 per output handshake, wrapping 0xFFFF -> 0x0000.
REQ-035 With LANES == 1 every accepted beat SHALL be a complete transfer with out_count=1.

Reset
REQ-036 On rst=1 at a clock edge: out_valid=0, out_data=0, out_count=0, out_last=0, acc_cnt=0, accumulator=0, flush_pend=0, xfer_cnt=0.
REQ-037 Reset mid-transfer SHALL discard the partial accumulator and any held output word; in_ready=1 the cycle after reset deasserts.
REQ-038 rst SHALL dominate all simultaneous in_valid, flush and out_ready activity.

Verification (DATA_W=8, LANES=4 unless noted)
REQ-039 Beats 0x11,0x22,0x33,0x44, out_ready=1 -> next cycle out_data=0x44332211, out_count=4, out_last=0, xfer_cnt=1.
REQ-040 Beats 0xAA, 0xBB(in_last=1) -> out_data=0x0000BBAA, out_count=2, out_last=1.
REQ-041 Word held with out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0, out_data stable; out_ready=1 -> handshake, next beat accepted same cycle.
REQ-042 Beats 0x01,0x02,0x03 then flush pulse -> out_data=0x00030201, out_count=3, out_last=0; flush at acc_cnt=0 then beat 0x55 -> out_count=1.
REQ-043 rst after 2 beats, then beats 0x10..0x13 -> out_data=0x13121110, out_count=4; preset xfer_cnt=0xFFFF via 65535 transfers, one more -> 0x0000.
REQ-044 LANES=1: continuous beats with out_ready=1 -> one transfer per cycle, out_count=1, no bubbles.
